// File: rtl/mem_tile_reader.sv
// Small power-of-two FIFO holding fetched pixels between memory and consumer.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: no internal throttling; the writer must never push when full.
module mem_tile_reader_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Pointer/count update; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push && pop) cnt_d = cnt_q - CNT_ONE;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = cnt_q;
  assign empty    = (cnt_q == '0);

endmodule

// Raster-order tile walker reading memory port A and streaming pixels out.
// Latency: first pixel valid 3 cycles after start, then one pixel per cycle.
// Backpressure: reads issue only when the skid FIFO has room for the in-flight word.
module mem_tile_reader #(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 18,
  parameter int DIM_W      = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  tile_w,
  input  logic [DIM_W-1:0]  tile_h,
  input  logic [DIM_W-1:0]  line_stride,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIM_W-1:0] DIM_ONE   = DIM_W'(1);
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } pix_t;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  tile_w_q, tile_w_d;
  logic [DIM_W-1:0]  tile_h_q, tile_h_d;
  logic [DIM_W-1:0]  stride_q, stride_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_pop;
  pix_t              push_pix;
  pix_t              head_pix;
  logic [CNT_W:0]    occ;
  logic              issue;
  logic              col_last;
  logic              row_last;
  logic              last_issue;
  logic              last_hs;
  logic [ADDR_W-1:0] issue_addr;

  // The word returned this cycle lands in the FIFO, carrying its last tag.
  assign push_pix.last = inflight_last_q;
  assign push_pix.data = mem_data;

  mem_tile_reader_fifo #(
    .WIDTH ($bits(pix_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_dat (push_pix),
    .pop      (fifo_pop),
    .head_dat (head_pix),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  // Issue qualification: a slot must remain for the word this read will return.
  always_comb begin
    fifo_pop   = !fifo_empty && out_ready;
    last_hs    = fifo_pop && head_pix.last;
    occ        = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, fifo_pop};
    issue      = (state_q == S_ISSUE) && (occ < DEPTH_LIM);
    col_last   = (col_q == tile_w_q - DIM_ONE);
    row_last   = (row_q == tile_h_q - DIM_ONE);
    last_issue = col_last && row_last;
    issue_addr = row_base_q + ADDR_W'(col_q);
    mem_addr_d = issue ? issue_addr : mem_addr_q;
  end

  // State and walker registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      tile_w_q        <= '0;
      tile_h_q        <= '0;
      stride_q        <= '0;
      col_q           <= '0;
      row_q           <= '0;
      row_base_q      <= '0;
      mem_addr_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      tile_w_q        <= tile_w_d;
      tile_h_q        <= tile_h_d;
      stride_q        <= stride_d;
      col_q           <= col_d;
      row_q           <= row_d;
      row_base_q      <= row_base_d;
      mem_addr_q      <= mem_addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  // Next-state and raster counter advance.
  always_comb begin
    state_d         = state_q;
    tile_w_d        = tile_w_q;
    tile_h_d        = tile_h_q;
    stride_d        = stride_q;
    col_d           = col_q;
    row_d           = row_q;
    row_base_d      = row_base_q;
    done_d          = 1'b0;
    inflight_d      = issue;
    inflight_last_d = issue && last_issue;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tile_w_d   = tile_w;
          tile_h_d   = tile_h;
          stride_d   = line_stride;
          col_d      = '0;
          row_d      = '0;
          row_base_d = base_addr;
          // An empty tile finishes immediately without ever going busy.
          if (tile_w == '0 || tile_h == '0) done_d = 1'b1;
          else                              state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          if (col_last) begin
            col_d      = '0;
            row_d      = row_q + DIM_ONE;
            row_base_d = row_base_q + ADDR_W'(stride_q);
          end else begin
            col_d = col_q + DIM_ONE;
          end
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_hs) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: stream from FIFO head, status from state.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = done_q;
    out_valid = !fifo_empty;
    out_data  = fifo_empty ? '0 : head_pix.data;
    out_last  = !fifo_empty && head_pix.last;
    mem_addr  = mem_addr_d;
  end

endmodule

// File: tb/tb_mem_tile_reader.sv
module tb_mem_tile_reader;
  logic        clk;
  logic        rst;
  logic        start;
  logic [20:0] base_addr;
  logic [9:0]  tile_w;
  logic [9:0]  tile_h;
  logic [9:0]  line_stride;
  logic [20:0] mem_addr;
  logic [17:0] mem_data;
  logic [17:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int ready_ph = 0;

  // Reference model state (owned by the monitor process).
  logic [18:0] exp_q[$];
  bit          m_busy = 0;
  bit          m_done = 0;
  int          start_cyc = 0;
  int          tile_hs = 0;
  int          tile_npix = 0;
  int          tile_mode = 0;
  bit          seen_valid = 0;
  logic [20:0] tile_max_addr = '0;
  bit          prev_stall = 0;
  logic [18:0] prev_dat = '0;

  mem_tile_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .tile_w      (tile_w),
    .tile_h      (tile_h),
    .line_stride (line_stride),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  // Memory content: word[i] = i below 2^18, upper address bits folded in above.
  function automatic logic [17:0] word(input logic [20:0] a);
    return a[17:0] ^ {a[20:18], 15'd0};
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory port A: one-cycle registered read.
  initial mem_data = '0;
  always @(posedge clk) mem_data <= word(mem_addr);

  // Consumer ready patterns: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1;
        1: begin
          out_ready = (ready_ph == 0 || ready_ph == 3);
          ready_ph  = (ready_ph + 1) % 4;
        end
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard: checks each cycle, then advances the model.
  initial forever begin
    bit was_busy;
    bit hs;
    logic [18:0] e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      m_busy     = 0;
      m_done     = 0;
      prev_stall = 0;
    end else begin
      was_busy = m_busy;
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (!m_busy) chk("idle_no_valid", out_valid, 0);
      if (m_busy && mem_addr > tile_max_addr) tile_max_addr = mem_addr;
      if (m_busy && out_valid && !seen_valid) begin
        seen_valid = 1;
        chk("first_valid_latency", cyc - start_cyc, 3);
      end
      if (prev_stall) chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_dat});
      hs = out_valid && out_ready;
      m_done = 0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got data %0d expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("pixel_data", out_data, e[17:0]);
          chk("pixel_last", out_last, e[18]);
          tile_hs++;
          if (e[18]) begin
            m_busy = 0;
            m_done = 1;
            if (tile_mode == 0) chk("throughput_last_cycle", cyc - start_cyc, tile_npix + 2);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = {out_last, out_data};
      if (start && !was_busy) begin
        if (tile_w == 0 || tile_h == 0) begin
          m_done = 1;
        end else begin
          m_busy        = 1;
          start_cyc     = cyc;
          tile_hs       = 0;
          seen_valid    = 0;
          tile_mode     = ready_mode;
          tile_npix     = int'(tile_w) * int'(tile_h);
          tile_max_addr = '0;
          for (int r = 0; r < int'(tile_h); r++)
            for (int c = 0; c < int'(tile_w); c++) begin
              logic [20:0] a;
              a = 21'(longint'(base_addr) + longint'(r) * longint'(line_stride) + longint'(c));
              exp_q.push_back({(r == int'(tile_h) - 1 && c == int'(tile_w) - 1), word(a)});
            end
        end
      end
    end
  end

  task automatic pulse_start(input int b, input int w, input int h, input int s);
    @(posedge clk);
    #1;
    base_addr   = 21'(b);
    tile_w      = 10'(w);
    tile_h      = 10'(h);
    line_stride = 10'(s);
    start       = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic launch(input int b, input int w, input int h, input int s, input int mode);
    ready_mode = mode;
    pulse_start(b, w, h, s);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_busy || m_done) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("tile_complete", longint'(m_busy || m_done), 0);
    if (m_busy || m_done) begin
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
    end
  endtask

  task automatic run_tile(input int b, input int w, input int h, input int s, input int mode);
    launch(b, w, h, s, mode);
    wait_idle(30 * w * h + 50);
  endtask

  initial begin
    int n;
    rst = 1;
    start = 0;
    base_addr = '0;
    tile_w = '0;
    tile_h = '0;
    line_stride = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    rst = 0;

    run_tile(0, 10, 1, 10, 0);
    run_tile(2, 3, 2, 5, 0);
    chk("t2_max_mem_addr", tile_max_addr, 9);
    run_tile(0, 10, 1, 10, 1);
    run_tile(0, 0, 5, 3, 0);
    run_tile(0, 3, 0, 3, 1);
    run_tile(7, 1, 1, 1, 0);

    // Reset at the 4th handshake aborts; a fresh scan restarts at pixel 0.
    launch(0, 10, 1, 10, 0);
    n = 0;
    while (tile_hs < 4 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("reached_4th_hs", tile_hs, 4);
    #1 rst = 1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_mem_addr", mem_addr, 0);
    @(posedge clk);
    #1 rst = 0;
    run_tile(0, 10, 1, 10, 0);

    // A start while busy is ignored.
    launch(0, 10, 1, 10, 1);
    repeat (4) @(posedge clk);
    pulse_start(100, 5, 5, 7);
    wait_idle(400);

    // Randomized tiles, some with stray starts mid-scan.
    for (int t = 0; t < 25; t++) begin
      int b, w, h, s, m;
      b = (t % 3 == 0) ? int'($urandom_range(2097000, 2097151)) : int'($urandom_range(0, 2097151));
      w = $urandom_range(0, 7);
      h = $urandom_range(0, 6);
      s = $urandom_range(0, 1023);
      m = $urandom_range(0, 2);
      launch(b, w, h, s, m);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 10)) @(posedge clk);
        pulse_start(int'($urandom_range(0, 2097151)), $urandom_range(1, 4), $urandom_range(1, 4), 9);
      end
      wait_idle(30 * 64 + 50);
    end

    // Large tile wrapping the address space, random backpressure.
    run_tile(21'h1FFF00, 40, 30, 64, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
